// File: rtl/hazard_ctrl.sv
// Scoreboard-style hazard control with per-register in-flight write counters and a redirect FSM.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        ex_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_use,
  input  logic        id_rs2_use,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wen,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_rd_wen,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        if_valid,
  input  logic        id_ready,
  output logic        stall_id,
  output logic        flush_if,
  output logic        flush_id,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] busy_mask
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_e;

  state_e            state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [31:0]       nz, dec_hit, busy_eff;
  logic              sat, hazard, issue;

  // A source whose last in-flight writer retires this cycle is released immediately.
  always_comb begin
    nz       = '0;
    dec_hit  = '0;
    busy_eff = '0;
    for (int r = 1; r < 32; r++) begin
      nz[r]       = (cnt_q[r] != '0);
      dec_hit[r]  = wb_valid && wb_rd_wen && (wb_rd == 5'(r)) && nz[r];
      busy_eff[r] = nz[r] && !(dec_hit[r] && (cnt_q[r] == CNT_W'(1)));
    end
  end

  assign busy_mask   = nz;
  assign redirect_pc = target_q;
  assign sat    = id_rd_wen && (id_rd != 5'd0) && (cnt_q[id_rd] == '1);
  assign hazard = (id_rs1_use && busy_eff[id_rs1]) || (id_rs2_use && busy_eff[id_rs2]) || sat;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    redirect_valid = 1'b0;
    stall_id       = id_valid && hazard;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          target_d = ex_target;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        redirect_valid = 1'b1;
        flush_if       = 1'b1;
        flush_id       = 1'b1;
        state_d        = REFILL;
      end
      REFILL: begin
        stall_id = 1'b1;
        if (if_valid && id_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign issue = id_valid && ex_ready && !stall_id && (state_q == RUN) && !ex_redirect;

  always_comb begin
    for (int r = 0; r < 32; r++) cnt_d[r] = cnt_q[r];
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      if (issue && id_rd_wen && (id_rd == 5'(r)) && !dec_hit[r])
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (!(issue && id_rd_wen && (id_rd == 5'(r))) && dec_hit[r])
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      target_q <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_id && id_valid) perf_stall_q <= perf_stall_q + 32'd1;
      if ((state_q == RUN) && (state_d == FLUSH)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: RAW stalls, saturation, same-cycle inc/dec, x0, redirect FSM, reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_ready, id_rs1_use, id_rs2_use, id_rd_wen;
  logic        wb_valid, wb_rd_wen, ex_redirect, if_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [31:0] ex_target;
  logic        stall_id, flush_if, flush_id, redirect_valid;
  logic [31:0] redirect_pc, busy_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_ready(ex_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_rd_wen(wb_rd_wen), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .if_valid(if_valid), .id_ready(id_ready), .stall_id(stall_id), .flush_if(flush_if),
    .flush_id(flush_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy_mask(busy_mask)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; ex_ready = 1; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_rd = 0; id_rd_wen = 0; wb_valid = 0; wb_rd = 0; wb_rd_wen = 0;
    ex_redirect = 0; ex_target = 0; if_valid = 0; id_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_id); end
    n_vec++; if ({redirect_valid, flush_if, flush_id} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {redirect_valid, flush_if, flush_id}); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
  endtask

  task automatic test_raw();
    id_valid = 1; id_rd = 5; id_rd_wen = 1;
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL raw_issue: got %b want 0", stall_id); end
    step();
    id_rd = 10; id_rd_wen = 0; id_rs1 = 5; id_rs1_use = 1;
    settle();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b want 1", stall_id); end
    n_vec++; if (busy_mask !== 32'h0000_0020) begin n_err++; $display("FAIL raw_busy: got %h want 00000020", busy_mask); end
    step();
    settle();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL raw_stall_hold: got %b want 1", stall_id); end
    step();
    wb_valid = 1; wb_rd = 5; wb_rd_wen = 1;
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL raw_release: got %b want 0", stall_id); end
    n_vec++; if (busy_mask[5] !== 1'b1) begin n_err++; $display("FAIL raw_busy_pre: got %b want 1", busy_mask[5]); end
    step();
    idle_inputs();
    settle();
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL raw_busy_post: got %h want 0", busy_mask); end
  endtask

  task automatic test_saturation();
    id_valid = 1; id_rd = 7; id_rd_wen = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL sat_issue%0d: got %b want 0", i, stall_id); end
      step();
    end
    settle();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL sat_stall: got %b want 1", stall_id); end
    step();
    wb_valid = 1; wb_rd = 7; wb_rd_wen = 1;
    settle();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL sat_wb_cycle: got %b want 1", stall_id); end
    step();
    wb_valid = 0;
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL sat_fourth: got %b want 0", stall_id); end
    step();
    idle_inputs();
    wb_valid = 1; wb_rd = 7; wb_rd_wen = 1;
    step();
    step();
    settle();
    n_vec++; if (busy_mask[7] !== 1'b1) begin n_err++; $display("FAIL sat_drain2: got %b want 1", busy_mask[7]); end
    step();
    idle_inputs();
    settle();
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL sat_drained: got %h want 0", busy_mask); end
  endtask

  task automatic test_same_cycle();
    id_valid = 1; id_rd = 9; id_rd_wen = 1;
    step();
    wb_valid = 1; wb_rd = 9; wb_rd_wen = 1;
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL same_stall: got %b want 0", stall_id); end
    step();
    idle_inputs();
    settle();
    n_vec++; if (busy_mask !== 32'h0000_0200) begin n_err++; $display("FAIL same_busy: got %h want 00000200", busy_mask); end
    wb_valid = 1; wb_rd = 9; wb_rd_wen = 1;
    step();
    idle_inputs();
    settle();
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL same_drain: got %h want 0", busy_mask); end
  endtask

  task automatic test_x0();
    id_valid = 1; id_rd = 0; id_rd_wen = 1; id_rs1 = 0; id_rs1_use = 1;
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", stall_id); end
    step();
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL x0_stall2: got %b want 0", stall_id); end
    step();
    idle_inputs();
    settle();
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
  endtask

  task automatic test_redirect();
    id_valid = 1; id_rd = 3; id_rd_wen = 1;
    ex_redirect = 1; ex_target = 32'h8000_0040;
    settle();
    n_vec++; if ({flush_if, flush_id, redirect_valid} !== 3'b110) begin n_err++; $display("FAIL redir_run: got %b want 110", {flush_if, flush_id, redirect_valid}); end
    step();
    idle_inputs();
    ex_redirect = 1; ex_target = 32'h1234_5678;
    settle();
    n_vec++; if ({flush_if, flush_id, redirect_valid} !== 3'b111) begin n_err++; $display("FAIL redir_flush: got %b want 111", {flush_if, flush_id, redirect_valid}); end
    n_vec++; if (redirect_pc !== 32'h8000_0040) begin n_err++; $display("FAIL redir_pc: got %h want 80000040", redirect_pc); end
    step();
    ex_redirect = 0;
    settle();
    n_vec++; if ({stall_id, flush_if, flush_id, redirect_valid} !== 4'b1000) begin n_err++; $display("FAIL redir_refill: got %b want 1000", {stall_id, flush_if, flush_id, redirect_valid}); end
    n_vec++; if (redirect_pc !== 32'h8000_0040) begin n_err++; $display("FAIL redir_pc_hold: got %h want 80000040", redirect_pc); end
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL redir_no_issue: got %h want 0", busy_mask); end
    step();
    if_valid = 1; id_ready = 1;
    settle();
    n_vec++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL redir_refill_hs: got %b want 1", stall_id); end
    step();
    idle_inputs();
    settle();
    n_vec++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL redir_back_run: got %b want 0", stall_id); end
  endtask

  task automatic test_rst_refill();
    id_valid = 1; id_rd = 4; id_rd_wen = 1;
    step();
    idle_inputs();
    ex_redirect = 1; ex_target = 32'hDEAD_BEE0;
    step();
    ex_redirect = 0;
    step();
    rst = 1; ex_redirect = 1; ex_target = 32'h0000_1000;
    wb_valid = 1; wb_rd = 4; wb_rd_wen = 1; id_valid = 1; id_rd = 8; id_rd_wen = 1;
    step();
    rst = 0;
    idle_inputs();
    settle();
    n_vec++; if ({stall_id, flush_if, flush_id, redirect_valid} !== 4'b0000) begin n_err++; $display("FAIL rst_refill_flags: got %b want 0000", {stall_id, flush_if, flush_id, redirect_valid}); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_refill_pc: got %h want 0", redirect_pc); end
    n_vec++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL rst_refill_busy: got %h want 0", busy_mask); end
    ex_redirect = 1; ex_target = 32'h0000_0100;
    settle();
    n_vec++; if ({flush_if, flush_id} !== 2'b11) begin n_err++; $display("FAIL rst_refill_run: got %b want 11", {flush_if, flush_id}); end
    step();
    idle_inputs();
    step();
    if_valid = 1; id_ready = 1;
    step();
    idle_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    id_valid = 1; id_rd = 6; id_rd_wen = 1;
    step();
    id_rd_wen = 0; id_rs1 = 6; id_rs1_use = 1;
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    wb_valid = 1; wb_rd = 6; wb_rd_wen = 1;
    step();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      ex_redirect = 1; ex_target = 32'h40;
      step();
      ex_redirect = 0;
      step();
      if_valid = 1; id_ready = 1;
      step();
      idle_inputs();
      step();
    end
    settle();
    n_vec++; if (perf_stall_cycles !== 32'd4) begin n_err++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cycles); end
    n_vec++; if (perf_flushes !== 32'd2) begin n_err++; $display("FAIL perf_flushes: got %0d want 2", perf_flushes); end
  endtask
`endif

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_raw();
    test_saturation();
    test_same_cycle();
    test_x0();
    test_redirect();
    test_rst_refill();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
